caf_read_sequencer: RTL and testbench
=====================================

# caf_read_sequencer

Address sequencer for the cross-ambiguity correlation pass. After a capture completes, it walks every lag of the sliding correlation. For each lag it issues paired read addresses to the reference buffer and the capture buffer, then waits for the per-lag correlator result before moving to the next lag. It replaces the inline address-counting logic of the CAF top level with a self-contained, stallable block.

## Interface
Parameters:
- ref_length, 64: reference buffer length, in samples.
- cap_length, 128: capture buffer length, in samples. Must satisfy cap_length >= ref_length; other values are unsupported.
- ref_index_bits, 6: width of the reference address; ref_length <= 2^ref_index_bits.
- cap_index_bits, 7: width of the capture address; cap_length <= 2^cap_index_bits.
- lag_bits, 7: width of the lag counter; holds up to cap_length - ref_length.

Ports:
- clk  in  1  Single clock. All logic is rising-edge.
- rst  in  1  Reset. **Asynchronous and active-high.**
- start  in  1  Start a pass. Sampled only in IDLE.
- abort  in  1  Synchronous abort. Returns to IDLE from any state.
- busy  out  1  High in every state except IDLE.
- done  out  1  One-cycle pulse at the end of a completed pass.
- m_axi_ref_raddr  out  ref_index_bits  Reference read address.
- m_axi_ref_rvalid  out  1  Reference address valid.
- s_axi_ref_rready  in  1  Reference buffer accepts an address.
- m_axi_cap_raddr  out  cap_index_bits  Capture read address.
- m_axi_cap_rvalid  out  1  Capture address valid. Always equal to m_axi_ref_rvalid.
- s_axi_cap_rready  in  1  Capture buffer accepts an address.
- lag  out  lag_bits  Lag currently being issued or awaited.
- last  out  1  High while the final address pair of the current lag is presented.
- s_axis_res_tvalid  in  1  Correlator result valid for the current lag.
- m_axis_res_tready  out  1  Sequencer accepts the result.

## Operation
- Lags: num_lags = cap_length - ref_length + 1. Lag L reads ref address k and capture address L + k, for k = 0 .. ref_length-1.
- Beat: an address pair transfers when rvalid, s_axi_ref_rready and s_axi_cap_rready are all high in the same cycle. No partial transfers occur. Addresses, rvalid and last hold while not accepted.
- States:
  - IDLE
    - Outputs low/zero.
    - start=1 and abort=0 → ISSUE with k=0, lag=0.
  - ISSUE
    - rvalid=1.
    - Beat with k < ref_length-1 → k+1.
    - Beat with k = ref_length-1 → WAIT_RES. rvalid drops next cycle.
  - WAIT_RES
    - m_axis_res_tready=1.
    - s_axis_res_tvalid=1 with lag < num_lags-1 → ISSUE with lag+1, k=0.
    - s_axis_res_tvalid=1 with lag = num_lags-1 → DONE.
  - DONE
    - done=1 for one cycle → IDLE.
- last = (state==ISSUE) && (k==ref_length-1).
- s_axis_res_tvalid is ignored outside WAIT_RES, where m_axis_res_tready=0.
- Address arithmetic is unsigned. Capture address = lag + k, zero-extended to cap_index_bits. Its maximum is cap_length-1, so it never wraps.
- Counter k resets to 0 at the start of each lag. lag increments only on a result handshake.

## Timing
- Reset values: busy=0, done=0, both rvalid=0, both raddr=0, lag=0, last=0, m_axis_res_tready=0, state=IDLE.
- Start latency: start sampled at edge N gives rvalid=1 with addresses 0/0 after edge N.
- Issue rate: with both readies held high, one beat per cycle; a lag issues in ref_length cycles.
- Result handshake: the handshake cycle in WAIT_RES is followed by the first beat of the next lag on the next cycle, i.e. zero bubble beyond the handshake itself.
- Pass length with readies high and results returned R cycles after entering WAIT_RES: num_lags·(ref_length + R + 1) + 1 cycles from the first rvalid to done.
- abort has priority over all transitions, including start and a same-cycle result handshake.
  - The next state is IDLE.
  - All outputs return to their reset values.
  - done is not pulsed.
- start while busy is ignored.
- Asynchronous rst mid-pass forces the reset values immediately. No done is produced.
- done and busy: done is high in the DONE cycle, where busy is still 1. busy=0 from the following cycle.

## Test plan
- **Nominal pass.**
  - Stimulus: ref_length=4, cap_length=7, readies high, res_tvalid 2 cycles after WAIT_RES entry.
  - Response: 4 lags, 16 beats. Capture addresses 0,1,2,3 / 1,2,3,4 / 2,3,4,5 / 3,4,5,6. last on every 4th beat. A single done pulse.
- **Backpressure.**
  - Stimulus: same config, s_axi_cap_rready low on alternating cycles.
  - Response: the beat sequence matches the nominal pass. Addresses are stable during stalls. No beat is counted while either ready is low.
- **Result gating.**
  - Stimulus: res_tvalid pulsed during ISSUE, then held low for 10 cycles in WAIT_RES.
  - Response: the pulse is ignored. The sequencer waits in WAIT_RES with lag unchanged and tready=1.
- **Abort.**
  - Stimulus: abort at lag=2, k=1; a separate run asserts abort coincident with a result handshake.
  - Response: IDLE next cycle, all outputs zero, no done.
- **Reset mid-pass.**
  - Stimulus: rst asserted between edges during ISSUE at lag=1.
  - Response: outputs reach reset values before the next edge. A new start runs a full pass from lag 0.
- **Degenerate lengths.**
  - Stimulus: ref_length=cap_length=4.
  - Response: exactly 1 lag, addresses 0..3 on both buffers, done after one result.

Source files
------------

// File: rtl/caf_read_sequencer.sv
// caf_read_sequencer
// -----------------------------------------------------------------------------
// Address sequencer for the cross-ambiguity correlation pass. Once started, it
// walks every lag L = 0 .. cap_length-ref_length. For each lag it issues the
// paired read addresses (ref k, capture L+k) for k = 0 .. ref_length-1. It then
// waits for the correlator result for that lag before moving to the next lag.
//
// Ports
//   clk                in   single rising-edge clock
//   rst                in   asynchronous, active-high reset
//   start              in   begin a pass (only looked at while idle)
//   abort              in   synchronous abort back to idle, no done pulse
//   busy               out  high in every state except idle
//   done               out  one-cycle pulse at the end of a completed pass
//   m_axi_ref_raddr    out  reference buffer read address (k)
//   m_axi_ref_rvalid   out  address pair valid
//   s_axi_ref_rready   in   reference buffer accepts the address
//   m_axi_cap_raddr    out  capture buffer read address (lag + k)
//   m_axi_cap_rvalid   out  identical to m_axi_ref_rvalid
//   s_axi_cap_rready   in   capture buffer accepts the address
//   lag                out  lag being issued or awaited
//   last               out  final address pair of the current lag presented
//   s_axis_res_tvalid  in   correlator result valid
//   m_axis_res_tready  out  result accepted (high only while waiting)
//
// Every output is a flop. Each output is loaded from the next-state decode, so
// it is valid in the same cycle the state register enters the matching state.
// -----------------------------------------------------------------------------
module caf_read_sequencer #(
    parameter int ref_length     = 64,
    parameter int cap_length     = 128,
    parameter int ref_index_bits = 6,
    parameter int cap_index_bits = 7,
    parameter int lag_bits       = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic [ref_index_bits-1:0] m_axi_ref_raddr,
    output logic                      m_axi_ref_rvalid,
    input  logic                      s_axi_ref_rready,
    output logic [cap_index_bits-1:0] m_axi_cap_raddr,
    output logic                      m_axi_cap_rvalid,
    input  logic                      s_axi_cap_rready,
    output logic [lag_bits-1:0]       lag,
    output logic                      last,
    input  logic                      s_axis_res_tvalid,
    output logic                      m_axis_res_tready
);

    localparam int NUM_LAGS = cap_length - ref_length + 1;
    localparam logic [ref_index_bits-1:0] K_LAST   = ref_index_bits'(ref_length - 1);
    localparam logic [lag_bits-1:0]       LAG_LAST = lag_bits'(NUM_LAGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_next_s;
    logic [ref_index_bits-1:0] k_r;
    logic [ref_index_bits-1:0] k_next_s;
    logic [lag_bits-1:0]       lag_r;
    logic [lag_bits-1:0]       lag_next_s;

    logic                      beat_s;
    logic                      res_hs_s;

    logic                      busy_next_s;
    logic                      done_next_s;
    logic                      rvalid_next_s;
    logic                      last_next_s;
    logic                      tready_next_s;
    logic [ref_index_bits-1:0] ref_raddr_next_s;
    logic [cap_index_bits-1:0] cap_raddr_next_s;

    logic                      busy_r;
    logic                      done_r;
    logic                      rvalid_r;
    logic                      last_r;
    logic                      tready_r;
    logic [ref_index_bits-1:0] ref_raddr_r;
    logic [cap_index_bits-1:0] cap_raddr_r;

    // Next-state decode: beat/result handshakes drive k and lag, abort overrides all.
    always_comb begin
        state_next_s = state_r;
        k_next_s     = k_r;
        lag_next_s   = lag_r;
        // rvalid is high exactly in ISSUE, so the beat only needs both readies.
        beat_s       = (state_r == ST_ISSUE) && s_axi_ref_rready && s_axi_cap_rready;
        // tready is high exactly in WAIT_RES; tvalid elsewhere is ignored.
        res_hs_s     = (state_r == ST_WAIT_RES) && s_axis_res_tvalid;

        if (abort) begin
            state_next_s = ST_IDLE;
            k_next_s     = {ref_index_bits{1'b0}};
            lag_next_s   = {lag_bits{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    k_next_s   = {ref_index_bits{1'b0}};
                    lag_next_s = {lag_bits{1'b0}};
                    if (start) begin
                        state_next_s = ST_ISSUE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (beat_s) begin
                        if (k_r == K_LAST) begin
                            // k stays at its last value; addresses are masked while waiting.
                            state_next_s = ST_WAIT_RES;
                        end else begin
                            k_next_s = k_r + ref_index_bits'(1);
                        end
                    end else begin
                        state_next_s = ST_ISSUE;
                    end
                end
                ST_WAIT_RES: begin
                    if (res_hs_s) begin
                        if (lag_r == LAG_LAST) begin
                            state_next_s = ST_DONE;
                        end else begin
                            // Straight back to ISSUE: no bubble after the handshake.
                            state_next_s = ST_ISSUE;
                            lag_next_s   = lag_r + lag_bits'(1);
                            k_next_s     = {ref_index_bits{1'b0}};
                        end
                    end else begin
                        state_next_s = ST_WAIT_RES;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_IDLE;
                    k_next_s     = {ref_index_bits{1'b0}};
                    lag_next_s   = {lag_bits{1'b0}};
                end
                default: begin
                    state_next_s = ST_IDLE;
                    k_next_s     = {ref_index_bits{1'b0}};
                    lag_next_s   = {lag_bits{1'b0}};
                end
            endcase
        end
    end

    // Output decode of the next state, so the registered outputs line up with the state register.
    always_comb begin
        busy_next_s      = 1'b0;
        done_next_s      = 1'b0;
        rvalid_next_s    = 1'b0;
        last_next_s      = 1'b0;
        tready_next_s    = 1'b0;
        ref_raddr_next_s = {ref_index_bits{1'b0}};
        cap_raddr_next_s = {cap_index_bits{1'b0}};
        case (state_next_s)
            ST_IDLE: begin
                busy_next_s = 1'b0;
            end
            ST_ISSUE: begin
                busy_next_s      = 1'b1;
                rvalid_next_s    = 1'b1;
                last_next_s      = (k_next_s == K_LAST);
                ref_raddr_next_s = k_next_s;
                // lag + k never exceeds cap_length-1, so the sum cannot wrap.
                cap_raddr_next_s = cap_index_bits'(lag_next_s) + cap_index_bits'(k_next_s);
            end
            ST_WAIT_RES: begin
                busy_next_s   = 1'b1;
                tready_next_s = 1'b1;
            end
            ST_DONE: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            k_r         <= {ref_index_bits{1'b0}};
            lag_r       <= {lag_bits{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rvalid_r    <= 1'b0;
            last_r      <= 1'b0;
            tready_r    <= 1'b0;
            ref_raddr_r <= {ref_index_bits{1'b0}};
            cap_raddr_r <= {cap_index_bits{1'b0}};
        end else begin
            state_r     <= state_next_s;
            k_r         <= k_next_s;
            lag_r       <= lag_next_s;
            busy_r      <= busy_next_s;
            done_r      <= done_next_s;
            rvalid_r    <= rvalid_next_s;
            last_r      <= last_next_s;
            tready_r    <= tready_next_s;
            ref_raddr_r <= ref_raddr_next_s;
            cap_raddr_r <= cap_raddr_next_s;
        end
    end

    assign busy              = busy_r;
    assign done              = done_r;
    assign m_axi_ref_raddr   = ref_raddr_r;
    assign m_axi_ref_rvalid  = rvalid_r;
    assign m_axi_cap_raddr   = cap_raddr_r;
    assign m_axi_cap_rvalid  = rvalid_r;
    assign lag               = lag_r;
    assign last              = last_r;
    assign m_axis_res_tready = tready_r;

endmodule

// File: tb/tb_caf_read_sequencer.sv
// Directed bench for caf_read_sequencer. Two instances are used: config A
// (ref 4 / cap 7, four lags) and config B (ref 4 / cap 4, one lag). Inputs
// change and outputs are sampled on the falling clock edge.
module tb_caf_read_sequencer;

    logic clk;
    logic rst;
    logic start_a;
    logic start_b;
    logic abort;
    logic ref_rready;
    logic cap_rready;
    logic res_tvalid;

    logic       a_busy, a_done, a_ref_rvalid, a_cap_rvalid, a_last, a_tready;
    logic [1:0] a_ref_raddr;
    logic [2:0] a_cap_raddr;
    logic [1:0] a_lag;

    logic       b_busy, b_done, b_ref_rvalid, b_cap_rvalid, b_last, b_tready;
    logic [1:0] b_ref_raddr;
    logic [1:0] b_cap_raddr;
    logic [0:0] b_lag;

    int sel_dut;
    logic       o_busy, o_done, o_ref_rvalid, o_cap_rvalid, o_last, o_tready;
    logic [7:0] o_ref, o_cap, o_lag;

    int n_checks;
    int n_failures;

    caf_read_sequencer #(
        .ref_length(4), .cap_length(7),
        .ref_index_bits(2), .cap_index_bits(3), .lag_bits(2)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .busy(a_busy), .done(a_done),
        .m_axi_ref_raddr(a_ref_raddr), .m_axi_ref_rvalid(a_ref_rvalid),
        .s_axi_ref_rready(ref_rready),
        .m_axi_cap_raddr(a_cap_raddr), .m_axi_cap_rvalid(a_cap_rvalid),
        .s_axi_cap_rready(cap_rready),
        .lag(a_lag), .last(a_last),
        .s_axis_res_tvalid(res_tvalid), .m_axis_res_tready(a_tready)
    );

    caf_read_sequencer #(
        .ref_length(4), .cap_length(4),
        .ref_index_bits(2), .cap_index_bits(2), .lag_bits(1)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .busy(b_busy), .done(b_done),
        .m_axi_ref_raddr(b_ref_raddr), .m_axi_ref_rvalid(b_ref_rvalid),
        .s_axi_ref_rready(ref_rready),
        .m_axi_cap_raddr(b_cap_raddr), .m_axi_cap_rvalid(b_cap_rvalid),
        .s_axi_cap_rready(cap_rready),
        .lag(b_lag), .last(b_last),
        .s_axis_res_tvalid(res_tvalid), .m_axis_res_tready(b_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation mux onto the instance under test.
    always_comb begin
        if (sel_dut == 0) begin
            o_busy = a_busy; o_done = a_done; o_ref_rvalid = a_ref_rvalid;
            o_cap_rvalid = a_cap_rvalid; o_last = a_last; o_tready = a_tready;
            o_ref = 8'(a_ref_raddr); o_cap = 8'(a_cap_raddr); o_lag = 8'(a_lag);
        end else begin
            o_busy = b_busy; o_done = b_done; o_ref_rvalid = b_ref_rvalid;
            o_cap_rvalid = b_cap_rvalid; o_last = b_last; o_tready = b_tready;
            o_ref = 8'(b_ref_raddr); o_cap = 8'(b_cap_raddr); o_lag = 8'(b_lag);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check_value({tag, "_busy"},   32'(o_busy),       32'd0);
        check_value({tag, "_done"},   32'(o_done),       32'd0);
        check_value({tag, "_rvalid"}, 32'(o_ref_rvalid), 32'd0);
        check_value({tag, "_crvld"},  32'(o_cap_rvalid), 32'd0);
        check_value({tag, "_raddr"},  32'(o_ref),        32'd0);
        check_value({tag, "_caddr"},  32'(o_cap),        32'd0);
        check_value({tag, "_lag"},    32'(o_lag),        32'd0);
        check_value({tag, "_last"},   32'(o_last),       32'd0);
        check_value({tag, "_tready"}, 32'(o_tready),     32'd0);
    endtask

    task automatic start_dut(input int sel);
        sel_dut = sel;
        if (sel == 0) begin
            start_a = 1'b1;
        end else begin
            start_b = 1'b1;
        end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Full pass with a reference model of the beat sequence (ref length 4).
    task automatic run_pass(input int sel, input bit bp, input int r_lat, input string name);
        int nlags, beat_idx, wait_cnt, cyc, done_cnt, done_cyc, ek, el;
        bit prev_stall;
        logic [7:0] prev_ref, prev_cap;
        nlags = (sel == 0) ? 4 : 1;
        beat_idx = 0; wait_cnt = 0; cyc = 0; done_cnt = 0; done_cyc = -1;
        prev_stall = 1'b0; prev_ref = 8'd0; prev_cap = 8'd0;
        ref_rready = 1'b1; cap_rready = 1'b1; res_tvalid = 1'b0;
        start_dut(sel);
        check_value({name, "_start_rvalid"}, 32'(o_ref_rvalid), 32'd1);
        while (cyc < 400 && done_cnt == 0) begin
            ref_rready = 1'b1;
            cap_rready = bp ? ((cyc % 2) == 0) : 1'b1;
            if (prev_stall) begin
                check_value({name, "_stall_ref"}, 32'(o_ref), 32'(prev_ref));
                check_value({name, "_stall_cap"}, 32'(o_cap), 32'(prev_cap));
            end
            if (o_ref_rvalid) begin
                check_value({name, "_cap_rvalid"}, 32'(o_cap_rvalid), 32'd1);
                if (ref_rready && cap_rready) begin
                    ek = beat_idx % 4;
                    el = beat_idx / 4;
                    check_value({name, "_ref_addr"}, 32'(o_ref),  32'(ek));
                    check_value({name, "_cap_addr"}, 32'(o_cap),  32'(el + ek));
                    check_value({name, "_lag"},      32'(o_lag),  32'(el));
                    check_value({name, "_last"},     32'(o_last), 32'(ek == 3));
                    beat_idx++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_ref = o_ref;
                    prev_cap = o_cap;
                end
            end else begin
                prev_stall = 1'b0;
            end
            if (o_tready) begin
                res_tvalid = (wait_cnt == r_lat);
                wait_cnt++;
            end else begin
                res_tvalid = 1'b0;
                wait_cnt = 0;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                check_value({name, "_busy_at_done"}, 32'(o_busy), 32'd1);
            end
            tick();
            cyc++;
        end
        res_tvalid = 1'b0;
        cap_rready = 1'b1;
        check_value({name, "_done_seen"}, 32'(done_cnt), 32'd1);
        check_value({name, "_beats"}, 32'(beat_idx), 32'(nlags * 4));
        if (!bp) begin
            check_value({name, "_pass_len"}, 32'(done_cyc), 32'(nlags * (4 + r_lat + 1)));
        end
        check_value({name, "_done_after"}, 32'(o_done), 32'd0);
        check_value({name, "_busy_after"}, 32'(o_busy), 32'd0);
    endtask

    // Run with ready/result immediate until the DUT presents (lag, k) in ISSUE.
    task automatic advance_to(input int want_lag, input int want_k, input string tag);
        bit found;
        found = 1'b0;
        ref_rready = 1'b1; cap_rready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (o_ref_rvalid && o_lag == 8'(want_lag) && o_ref == 8'(want_k)) begin
                found = 1'b1;
                break;
            end
            res_tvalid = o_tready;
            tick();
        end
        res_tvalid = 1'b0;
        check_value(tag, 32'(found), 32'd1);
    endtask

    initial begin
        n_checks = 0; n_failures = 0; sel_dut = 0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        ref_rready = 1'b0; cap_rready = 1'b0; res_tvalid = 1'b0;
        tick(); tick();
        check_idle("rst_a");
        sel_dut = 1;
        check_idle("rst_b");
        sel_dut = 0;
        rst = 1'b0;
        tick();
        check_idle("post_rst");

        // Nominal and backpressure passes on the four-lag config.
        run_pass(0, 1'b0, 2, "nom");
        run_pass(0, 1'b1, 2, "bp");

        // Result gating: tvalid and start pulsed in ISSUE are ignored, then a long wait.
        ref_rready = 1'b1; cap_rready = 1'b1;
        start_dut(0);
        tick();
        check_value("gate_k1", 32'(o_ref), 32'd1);
        res_tvalid = 1'b1;
        start_a = 1'b1;
        check_value("gate_tready_issue", 32'(o_tready), 32'd0);
        tick();
        res_tvalid = 1'b0;
        start_a = 1'b0;
        check_value("gate_k2", 32'(o_ref), 32'd2);
        check_value("gate_lag_issue", 32'(o_lag), 32'd0);
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            check_value("gate_wait_tready", 32'(o_tready), 32'd1);
            check_value("gate_wait_lag", 32'(o_lag), 32'd0);
            check_value("gate_wait_rvalid", 32'(o_ref_rvalid), 32'd0);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("gate_abort");

        // Abort mid-issue at lag 2, k 1.
        start_dut(0);
        advance_to(2, 1, "abort_reach");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_issue");
        for (int i = 0; i < 3; i++) begin
            check_value("abort_no_done", 32'(o_done), 32'd0);
            tick();
        end

        // Abort coincident with a result handshake.
        start_dut(0);
        advance_to(0, 3, "abhs_reach");
        tick();
        check_value("abhs_tready", 32'(o_tready), 32'd1);
        res_tvalid = 1'b1;
        abort = 1'b1;
        tick();
        res_tvalid = 1'b0;
        abort = 1'b0;
        check_idle("abort_hs");

        // Abort beats a same-cycle start in IDLE.
        start_a = 1'b1;
        abort = 1'b1;
        tick();
        start_a = 1'b0;
        abort = 1'b0;
        check_value("abort_start_busy", 32'(o_busy), 32'd0);

        // Asynchronous reset between edges during lag 1.
        start_dut(0);
        advance_to(1, 0, "rst_reach");
        check_value("rst_pre_busy", 32'(o_busy), 32'd1);
        #2 rst = 1'b1;
        #1 check_idle("rst_async");
        #1 rst = 1'b0;
        tick();
        run_pass(0, 1'b0, 2, "after_rst");

        // Degenerate: ref and capture of equal length, single lag.
        run_pass(1, 1'b0, 1, "degen");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
